// File: rtl/reg_bank_encapsulation_pkg.sv
// Shared constants and select encodings for the ARMv4 register bank.
// Build option: REG_BANK_PC_PLUS8_EN makes index-15 reads return PC+8.
package reg_bank_encapsulation_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    RM_IR_3_0   = 2'd0,
    RM_IR_15_12 = 2'd1,
    RM_COUNTER  = 2'd2,
    RM_IR_19_16 = 2'd3
  } rm_sel_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_ALU      = 2'd2,
    PC_HOLD_ALT = 2'd3
  } pc_sel_e;

  typedef enum logic {
    DATA_ALU = 1'b0,
    DATA_B   = 1'b1
  } data_sel_e;

  localparam logic [DATA_W-1:0] PC_RESET_VALUE = 32'h0000_0000;
  localparam logic [DATA_W-1:0] PC_INCR        = 32'd4;
  localparam logic [IDX_W-1:0]  R14            = 4'd14;
  localparam logic [IDX_W-1:0]  R15            = 4'd15;

  // Pipeline view of R15 seen by operand reads; the raw PC output is unaffected.
`ifdef REG_BANK_PC_PLUS8_EN
  localparam logic [DATA_W-1:0] PC_READ_OFFSET = 32'd8;
`else
  localparam logic [DATA_W-1:0] PC_READ_OFFSET = 32'd0;
`endif

endpackage

// File: rtl/reg_file_16x32.sv
// R0-R14 storage plus the PC, with four combinational read ports,
// one synchronous general write port and a dedicated PC write path.
module reg_file_16x32
  import reg_bank_encapsulation_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [IDX_W-1:0]  c_idx,
  input  logic [IDX_W-1:0]  st_idx,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] c_data,
  output logic [DATA_W-1:0] st_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_data,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] regs [0:R14];
  logic [DATA_W-1:0] pc_view;

  assign pc_view = pc + PC_READ_OFFSET;

  // Index 15 never touches the array; the PC path owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= int'(R14); i++) begin
        regs[IDX_W'(i)] <= '0;
      end
      pc <= PC_RESET_VALUE;
    end else begin
      if (we && (wr_idx != R15)) begin
        regs[wr_idx] <= wr_data;
      end
      if (pc_we) begin
        pc <= pc_data;
      end
    end
  end

  assign a_data  = (a_idx  == R15) ? pc_view : regs[a_idx];
  assign b_data  = (b_idx  == R15) ? pc_view : regs[b_idx];
  assign c_data  = (c_idx  == R15) ? pc_view : regs[c_idx];
  assign st_data = (st_idx == R15) ? pc_view : regs[st_idx];

endmodule

// File: rtl/reg_bank_encapsulation.sv
// ARMv4 register bank top: index/data selection, bus gating and PC update priority.
// Build option: REG_BANK_PC_PLUS8_EN (see package).
module reg_bank_encapsulation
  import reg_bank_encapsulation_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              LATCH_REG,
  input  logic              IR_RD_MUX,
  input  logic              RD_MUX,
  input  logic              IR_RN_MUX,
  input  logic [1:0]        IR_RM_MUX,
  input  logic              DATA_MUX,
  input  logic [1:0]        PC_MUX,
  input  logic              REG_GATE_B,
  input  logic              REG_GATE_C,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] ALU_BUS,
  input  logic [IDX_W-1:0]  REG_COUNTER,
  output logic [DATA_W-1:0] A_BUS,
  inout  wire  [DATA_W-1:0] B_BUS,
  output logic [DATA_W-1:0] C_BUS,
  output logic [DATA_W-1:0] ST,
  output logic [DATA_W-1:0] PC
);

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rn_idx;
  logic [IDX_W-1:0]  rm_idx;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] c_data;
  logic [DATA_W-1:0] wr_data;
  logic              pc_we;
  logic [DATA_W-1:0] pc_data;

  wire unused_ir = ^{IR[31:20], IR[7:4]};

  assign rn_idx = IR_RN_MUX ? IR[15:12] : IR[19:16];
  assign rd_idx = RD_MUX ? REG_COUNTER : (IR_RD_MUX ? IR[19:16] : IR[15:12]);

  always_comb begin
    rm_idx = IR[3:0];
    unique case (rm_sel_e'(IR_RM_MUX))
      RM_IR_3_0:   rm_idx = IR[3:0];
      RM_IR_15_12: rm_idx = IR[15:12];
      RM_COUNTER:  rm_idx = REG_COUNTER;
      RM_IR_19_16: rm_idx = IR[19:16];
    endcase
  end

  // Write data comes off the shared B bus so external drivers can load the bank too.
  assign wr_data = (data_sel_e'(DATA_MUX) == DATA_B) ? B_BUS : ALU_BUS;

  // A register write targeting R15 wins over the PC_MUX update.
  always_comb begin
    pc_we   = 1'b0;
    pc_data = ALU_BUS;
    if (LATCH_REG && (rd_idx == R15)) begin
      pc_we   = 1'b1;
      pc_data = wr_data;
    end else begin
      unique case (pc_sel_e'(PC_MUX))
        PC_INC: begin
          pc_we   = 1'b1;
          pc_data = PC + PC_INCR;
        end
        PC_ALU: begin
          pc_we   = 1'b1;
          pc_data = ALU_BUS;
        end
        PC_HOLD, PC_HOLD_ALT: pc_we = 1'b0;
      endcase
    end
  end

  reg_file_16x32 u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .a_idx   (rn_idx),
    .b_idx   (rm_idx),
    .c_idx   (IR[11:8]),
    .st_idx  (IR[15:12]),
    .a_data  (A_BUS),
    .b_data  (b_data),
    .c_data  (c_data),
    .st_data (ST),
    .we      (LATCH_REG),
    .wr_idx  (rd_idx),
    .wr_data (wr_data),
    .pc_we   (pc_we),
    .pc_data (pc_data),
    .pc      (PC)
  );

  assign B_BUS = REG_GATE_B ? b_data : 'z;
  assign C_BUS = REG_GATE_C ? c_data : 'z;

endmodule

// File: tb/tb_reg_bank_encapsulation.sv
// Self-checking bench for reg_bank_encapsulation: directed scenarios plus
// randomized cycles against an array-based model of the sixteen registers.
module tb_reg_bank_encapsulation;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch_reg, ir_rd_mux, rd_mux, ir_rn_mux, data_mux;
  logic        reg_gate_b, reg_gate_c;
  logic [1:0]  ir_rm_mux, pc_mux;
  logic [31:0] ir, alu_bus;
  logic [3:0]  reg_counter;
  wire  [31:0] a_bus, b_bus, c_bus, st, pc;

  logic        tb_drive_b;
  logic [31:0] tb_b_val;
  assign b_bus = tb_drive_b ? tb_b_val : 'z;

  int compared;
  int mismatched;

  logic [31:0] m_r [16];
  logic [31:0] m_pc;

`ifdef REG_BANK_PC_PLUS8_EN
  localparam logic [31:0] PC_VIEW_OFF = 32'd8;
`else
  localparam logic [31:0] PC_VIEW_OFF = 32'd0;
`endif

  always #5 clk = ~clk;

  reg_bank_encapsulation dut (
    .clk         (clk),
    .rst         (rst),
    .LATCH_REG   (latch_reg),
    .IR_RD_MUX   (ir_rd_mux),
    .RD_MUX      (rd_mux),
    .IR_RN_MUX   (ir_rn_mux),
    .IR_RM_MUX   (ir_rm_mux),
    .DATA_MUX    (data_mux),
    .PC_MUX      (pc_mux),
    .REG_GATE_B  (reg_gate_b),
    .REG_GATE_C  (reg_gate_c),
    .IR          (ir),
    .ALU_BUS     (alu_bus),
    .REG_COUNTER (reg_counter),
    .A_BUS       (a_bus),
    .B_BUS       (b_bus),
    .C_BUS       (c_bus),
    .ST          (st),
    .PC          (pc)
  );

  function automatic logic [31:0] m_read(input logic [3:0] n);
    return (n == 4'd15) ? m_pc + PC_VIEW_OFF : m_r[n];
  endfunction

  function automatic logic [3:0] m_b_idx();
    case (ir_rm_mux)
      2'd0:    return ir[3:0];
      2'd1:    return ir[15:12];
      2'd2:    return reg_counter;
      default: return ir[19:16];
    endcase
  endfunction

  // One clock edge; the model takes the architectural effect of the current controls.
  task automatic tick();
    logic [3:0]  dest;
    logic [31:0] wd;
    dest = rd_mux ? reg_counter : (ir_rd_mux ? ir[19:16] : ir[15:12]);
    wd   = data_mux ? (reg_gate_b ? m_read(m_b_idx()) : tb_b_val) : alu_bus;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_pc = 32'h0;
    end else begin
      if (latch_reg && dest != 4'd15) m_r[dest] = wd;
      if (latch_reg && dest == 4'd15) m_pc = wd;
      else if (pc_mux == 2'd1)        m_pc = m_pc + 32'd4;
      else if (pc_mux == 2'd2)        m_pc = alu_bus;
    end
    #1;
  endtask

  task automatic idle_controls();
    rst = 0; latch_reg = 0; ir_rd_mux = 0; rd_mux = 0; ir_rn_mux = 0;
    data_mux = 0; reg_gate_b = 0; reg_gate_c = 0; ir_rm_mux = 0; pc_mux = 0;
    tb_drive_b = 0;
  endtask

  task automatic test_reset();
    idle_controls();
    rst = 1; latch_reg = 1; pc_mux = 2'd1; ir = 32'h0; alu_bus = 32'hDEAD_BEEF;
    reg_counter = 4'd0; tb_b_val = 32'h0;
    tick();
    rst = 1; tick();
    latch_reg = 0; pc_mux = 0; reg_gate_b = 1; reg_gate_c = 1;
    #1;
    compared++; if (pc !== 32'h0)    begin mismatched++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    compared++; if (a_bus !== 32'h0) begin mismatched++; $display("FAIL reset_a: got %h want %h", a_bus, 32'h0); end
    compared++; if (st !== 32'h0)    begin mismatched++; $display("FAIL reset_st: got %h want %h", st, 32'h0); end
    compared++; if (b_bus !== 32'h0) begin mismatched++; $display("FAIL reset_b_gated: got %h want %h", b_bus, 32'h0); end
    compared++; if (c_bus !== 32'h0) begin mismatched++; $display("FAIL reset_c_gated: got %h want %h", c_bus, 32'h0); end
    rst = 0;
  endtask

  task automatic test_write_read();
    idle_controls();
    ir = 32'h0000_3000; latch_reg = 1; alu_bus = 32'h1234_5678;
    tick();
    latch_reg = 0; ir = 32'h0003_3000;
    #1;
    compared++; if (a_bus !== 32'h1234_5678) begin mismatched++; $display("FAIL wr_a: got %h want %h", a_bus, 32'h1234_5678); end
    compared++; if (st !== 32'h1234_5678)    begin mismatched++; $display("FAIL wr_st: got %h want %h", st, 32'h1234_5678); end
    // Same-cycle read of a register being written shows the old value.
    latch_reg = 1; alu_bus = 32'hAAAA_0001;
    #1;
    compared++; if (st !== 32'h1234_5678) begin mismatched++; $display("FAIL rw_same_cycle: got %h want %h", st, 32'h1234_5678); end
    ir = 32'h0000_4000; alu_bus = 32'h0;
    tick();
    latch_reg = 0;
  endtask

  task automatic test_bus_gating();
    idle_controls();
    ir = 32'h0000_0300;
    tb_drive_b = 1; tb_b_val = 32'h5A5A_A5A5;
    #1;
    compared++; if (b_bus !== 32'h5A5A_A5A5) begin mismatched++; $display("FAIL b_released: got %h want %h", b_bus, 32'h5A5A_A5A5); end
    tb_drive_b = 0; ir_rm_mux = 2'd2; reg_counter = 4'd3; reg_gate_b = 1; reg_gate_c = 1;
    #1;
    compared++; if (b_bus !== 32'h1234_5678) begin mismatched++; $display("FAIL b_gated: got %h want %h", b_bus, 32'h1234_5678); end
    compared++; if (c_bus !== 32'h1234_5678) begin mismatched++; $display("FAIL c_gated: got %h want %h", c_bus, 32'h1234_5678); end
    // Register move R3 -> R5 over the B bus.
    ir = 32'h0000_5300; data_mux = 1; latch_reg = 1;
    tick();
    latch_reg = 0; data_mux = 0; ir_rn_mux = 1;
    #1;
    compared++; if (a_bus !== 32'h1234_5678) begin mismatched++; $display("FAIL reg_move: got %h want %h", a_bus, 32'h1234_5678); end
    // External driver loads R6 through the bus.
    reg_gate_b = 0; reg_gate_c = 0; tb_drive_b = 1; tb_b_val = 32'hC0DE_0042;
    ir = 32'h0000_6000; data_mux = 1; latch_reg = 1;
    tick();
    latch_reg = 0; data_mux = 0; tb_drive_b = 0;
    #1;
    compared++; if (st !== 32'hC0DE_0042) begin mismatched++; $display("FAIL ext_bus_write: got %h want %h", st, 32'hC0DE_0042); end
  endtask

  task automatic test_pc();
    idle_controls();
    rst = 1; tick(); rst = 0;
    pc_mux = 2'd1;
    repeat (3) tick();
    compared++; if (pc !== 32'hC) begin mismatched++; $display("FAIL pc_inc3: got %h want %h", pc, 32'hC); end
    pc_mux = 2'd2; alu_bus = 32'h100; tick();
    compared++; if (pc !== 32'h100) begin mismatched++; $display("FAIL pc_alu: got %h want %h", pc, 32'h100); end
    pc_mux = 2'd3; alu_bus = 32'h0; tick();
    compared++; if (pc !== 32'h100) begin mismatched++; $display("FAIL pc_hold3: got %h want %h", pc, 32'h100); end
    pc_mux = 2'd2; alu_bus = 32'hFFFF_FFFC; tick();
    pc_mux = 2'd1; tick();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL pc_wrap: got %h want %h", pc, 32'h0); end
    pc_mux = 2'd0;
  endtask

  task automatic test_priority();
    idle_controls();
    pc_mux = 2'd1; latch_reg = 1; rd_mux = 1; reg_counter = 4'd15; alu_bus = 32'h40;
    tick();
    compared++; if (pc !== 32'h40) begin mismatched++; $display("FAIL pc_priority: got %h want %h", pc, 32'h40); end
    latch_reg = 0; rd_mux = 0; pc_mux = 0;
    rst = 1; pc_mux = 2'd2; alu_bus = 32'h777; tick();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL rst_over_pc: got %h want %h", pc, 32'h0); end
    rst = 0; pc_mux = 0;
  endtask

  task automatic test_pc_view();
    idle_controls();
    pc_mux = 2'd2; alu_bus = 32'h100; tick();
    pc_mux = 0; ir = 32'h000F_F000;
    #1;
    compared++; if (a_bus !== 32'h100 + PC_VIEW_OFF) begin mismatched++; $display("FAIL pc_view_a: got %h want %h", a_bus, 32'h100 + PC_VIEW_OFF); end
    compared++; if (st !== 32'h100 + PC_VIEW_OFF)    begin mismatched++; $display("FAIL pc_view_st: got %h want %h", st, 32'h100 + PC_VIEW_OFF); end
    compared++; if (pc !== 32'h100) begin mismatched++; $display("FAIL pc_raw: got %h want %h", pc, 32'h100); end
  endtask

  task automatic test_random();
    logic [31:0] exp_b;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      latch_reg   = $urandom_range(0, 1);
      ir_rd_mux   = $urandom_range(0, 1);
      rd_mux      = $urandom_range(0, 1);
      ir_rn_mux   = $urandom_range(0, 1);
      ir_rm_mux   = 2'($urandom_range(0, 3));
      data_mux    = $urandom_range(0, 1);
      pc_mux      = 2'($urandom_range(0, 3));
      reg_gate_b  = ($urandom_range(0, 3) != 0);
      reg_gate_c  = $urandom_range(0, 1);
      ir          = $urandom;
      alu_bus     = $urandom;
      reg_counter = 4'($urandom_range(0, 15));
      tb_drive_b  = !reg_gate_b;
      tb_b_val    = $urandom;
      #1;
      compared++;
      if (a_bus !== m_read(ir_rn_mux ? ir[15:12] : ir[19:16])) begin
        mismatched++; $display("FAIL rand_a[%0d]: got %h want %h", n, a_bus, m_read(ir_rn_mux ? ir[15:12] : ir[19:16]));
      end
      compared++;
      if (st !== m_read(ir[15:12])) begin
        mismatched++; $display("FAIL rand_st[%0d]: got %h want %h", n, st, m_read(ir[15:12]));
      end
      compared++;
      if (pc !== m_pc) begin
        mismatched++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc, m_pc);
      end
      exp_b = reg_gate_b ? m_read(m_b_idx()) : tb_b_val;
      compared++;
      if (b_bus !== exp_b) begin
        mismatched++; $display("FAIL rand_b[%0d]: got %h want %h", n, b_bus, exp_b);
      end
      if (reg_gate_c) begin
        compared++;
        if (c_bus !== m_read(ir[11:8])) begin
          mismatched++; $display("FAIL rand_c[%0d]: got %h want %h", n, c_bus, m_read(ir[11:8]));
        end
      end
      tick();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_write_read();
    test_bus_gating();
    test_pc();
    test_priority();
    test_pc_view();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_bank_encapsulation.md
# reg_bank_encapsulation

Register bank of the ARMv4 datapath: sixteen 32-bit architectural registers (R0–R14, R15 = PC) with index selection from IR fields or an external counter. Reads are combinational onto the A, B and C buses and the ST store-data output; all writes are synchronous. The bank sits between the IR/ALU/memory-read paths and the control state machine, which drives every select and strobe.

## Interface
- Parameters: none. Reset PC value and PC increment come from the shared package.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- LATCH_REG  in  1  write strobe for the destination register.
- IR_RD_MUX  in  1  destination field: 0 = IR[15:12], 1 = IR[19:16].
- RD_MUX  in  1  destination source: 0 = field chosen by IR_RD_MUX, 1 = REG_COUNTER.
- IR_RN_MUX  in  1  A-port index: 0 = IR[19:16], 1 = IR[15:12].
- IR_RM_MUX  in  2  B-port index: 0 = IR[3:0], 1 = IR[15:12], 2 = REG_COUNTER, 3 = IR[19:16].
- DATA_MUX  in  1  write data: 0 = ALU_BUS, 1 = B_BUS.
- PC_MUX  in  2  PC update: 0 = hold, 1 = PC+4, 2 = ALU_BUS, 3 = hold.
- REG_GATE_B  in  1  drive B_BUS with the B-port register.
- REG_GATE_C  in  1  drive C_BUS with register IR[11:8] (Rs).
- IR  in  32  current instruction.
- ALU_BUS  in  32  ALU result.
- REG_COUNTER  in  4  register index from the control path.
- A_BUS  out  32  always driven.
- B_BUS  inout  32  shared tri-state bus.
- C_BUS  out  32  tri-state output.
- ST  out  32  store data: register IR[15:12].
- PC  out  32  raw R15 contents.

## Operation
- Read value of index n is Rn. For n = 15 the read value is PC, adjusted as described in Configuration.
- A_BUS carries the read value of the A-port index at all times.
- B_BUS carries the read value of the B-port index when REG_GATE_B = 1; otherwise it is 'z.
- C_BUS carries the read value of IR[11:8] when REG_GATE_C = 1; otherwise it is 'z.
- ST carries the read value of IR[15:12] at all times.
- Write: when LATCH_REG = 1, the destination register is loaded with the DATA_MUX-selected word on the clock edge.
- PC: updated per PC_MUX on every edge. A LATCH_REG write whose destination is 15 takes priority over PC_MUX.
- With DATA_MUX = 1 and REG_GATE_B = 1, the bank writes back its own B-port value (register move).

## Timing
- Reads are zero-latency combinational. A write becomes visible on the buses in the cycle after the edge.
- Reading and writing the same register in one cycle returns the old value.
- Reset (synchronous, any cycle, including mid-instruction) clears R0–R14 to 0 and sets PC to 0x0000_0000. rst overrides LATCH_REG and PC_MUX.
- Reset output values: A_BUS, ST and PC are 0. B_BUS and C_BUS are 'z unless gated; if gated, they show 0.
- PC+4 wraps modulo 2^32: 0xFFFF_FFFC becomes 0x0000_0000.
- No handshake. Control holds selects stable for the whole cycle.

## Configuration
- REG_BANK_PC_PLUS8_EN defined: any read of index 15 on A, B, C or ST returns PC+8 (ARM pipeline view, modulo 2^32). The PC output remains raw.
- Not defined: reads of index 15 return PC unmodified.

## Structure
- Shared package holds:
  - the encodings of IR_RM_MUX, PC_MUX and DATA_MUX;
  - PC_RESET_VALUE = 32'h0;
  - PC_INCR = 4;
  - the index constants R14 = 14 and R15 = 15.
- One natural sub-module: reg_file_16x32. It provides three combinational read ports, a fourth read port for ST, one synchronous write port, and a separate PC write path. The top level contains the index/data muxing, bus gating and PC priority logic.

## Test plan
- Reset: assert rst for one edge -> PC = 0; A_BUS = 0 for IR = 0x0000_0000; ALU_BUS = 0xDEAD_BEEF with LATCH_REG = 1 on the reset cycle is not written.
- Write/read: IR[15:12] = 3, LATCH_REG = 1, DATA_MUX = 0, ALU_BUS = 0x1234_5678 -> after the edge, IR[19:16] = 3 with IR_RN_MUX = 0 gives A_BUS = 0x1234_5678, and ST = 0x1234_5678.
- Bus gating: REG_GATE_B = 0 -> B_BUS = 'z. Set IR_RM_MUX = 2, REG_COUNTER = 3, REG_GATE_B = 1 -> B_BUS = 0x1234_5678.
- PC: PC_MUX = 1 for three edges -> PC = 0xC. Then PC_MUX = 2 with ALU_BUS = 0x100 -> PC = 0x100. With PC = 0xFFFF_FFFC, PC_MUX = 1 -> PC = 0.
- Priority: PC_MUX = 1, LATCH_REG = 1, RD_MUX = 1, REG_COUNTER = 15, ALU_BUS = 0x40 -> PC = 0x40.
- Macro: with REG_BANK_PC_PLUS8_EN defined and PC = 0x100, IR[19:16] = 15 -> A_BUS = 0x108 while PC = 0x100. Without the macro -> A_BUS = 0x100.
